// File: rtl/mul_div_unit_pkg.sv
// Shared op codes and FSM state encoding for the multiply/divide unit and the CU.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with fixed latencies.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  mdu_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic [3:0]       r_op, w_op_nxt;
  logic             r_busy;

  logic               w_issue;
  logic               w_mul_sgn, w_div_sgn, w_neg_a, w_neg_b;
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod, w_mul_res;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_dvsr, w_q_u, w_r_u, w_quot, w_rem;

  assign w_issue = start & ~req & (r_state == ST_IDLE);

  // Multiply datapath: sign/zero-extend to 2*WIDTH so the truncated product is exact.
  always_comb begin
    w_mul_sgn = (r_op == OP_MULT) | (r_op == OP_MADD) | (r_op == OP_MSUB);
    w_ext_a   = {{WIDTH{w_mul_sgn & r_a[WIDTH-1]}}, r_a};
    w_ext_b   = {{WIDTH{w_mul_sgn & r_b[WIDTH-1]}}, r_b};
    w_prod    = w_ext_a * w_ext_b;
    w_mul_res = w_prod;
`ifdef MDU_MADD_EN
    case (r_op)
      OP_MADD, OP_MADDU: w_mul_res = {r_hi, r_lo} + w_prod;
      OP_MSUB, OP_MSUBU: w_mul_res = {r_hi, r_lo} - w_prod;
      default:           w_mul_res = w_prod;
    endcase
`endif
  end

  // Divide datapath: magnitude divide, then restore signs (truncating toward zero).
  always_comb begin
    w_div_sgn = (r_op == OP_DIV);
    w_neg_a   = w_div_sgn & r_a[WIDTH-1];
    w_neg_b   = w_div_sgn & r_b[WIDTH-1];
    w_abs_a   = w_neg_a ? (W_ZERO - r_a) : r_a;
    w_abs_b   = w_neg_b ? (W_ZERO - r_b) : r_b;
    w_dvsr    = (r_b == W_ZERO) ? W_ONE : w_abs_b;
    w_q_u     = w_abs_a / w_dvsr;
    w_r_u     = w_abs_a % w_dvsr;
    w_quot    = (w_neg_a ^ w_neg_b) ? (W_ZERO - w_q_u) : w_q_u;
    w_rem     = w_neg_a ? (W_ZERO - w_r_u) : w_r_u;
  end

  // Next-state, counter and HI/LO update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          case (op)
            OP_MULT, OP_MULTU,
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
`endif
            OP_DIV, OP_DIVU: begin
              w_a_nxt     = rs_data;
              w_b_nxt     = rt_data;
              w_op_nxt    = op;
              w_state_nxt = ((op == OP_DIV) || (op == OP_DIVU)) ? ST_DIV : ST_MUL;
              w_cnt_nxt   = ((op == OP_DIV) || (op == OP_DIVU)) ? DIV_LOAD : MUL_LOAD;
            end
            OP_MTHI: w_hi_nxt = rs_data;
            OP_MTLO: w_lo_nxt = rs_data;
            default: w_state_nxt = ST_IDLE;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (r_cnt == CNT_ONE) begin
          w_hi_nxt    = w_mul_res[2*WIDTH-1:WIDTH];
          w_lo_nxt    = w_mul_res[WIDTH-1:0];
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_DIV: begin
        if (r_cnt == CNT_ONE) begin
          // A zero divisor still burns the full latency but leaves HI/LO alone.
          if (r_b != W_ZERO) begin
            w_hi_nxt = w_rem;
            w_lo_nxt = w_quot;
          end else begin
            w_hi_nxt = r_hi;
          end
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter, operand and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= W_ZERO;
      r_lo    <= W_ZERO;
      r_a     <= W_ZERO;
      r_b     <= W_ZERO;
      r_op    <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign busy    = r_busy;
  assign rd_data = (op == OP_MFHI) ? r_hi : r_lo;

endmodule
